vga_write_arbiter: RTL and testbench

//  Shares the single pixel write port of vga_adapter (x, y, colour, plot) between N drawing engines
//  (e.g. background clear, hit-circle drawer, score/cursor drawer) in part2.

---
 rtl/vga_write_arbiter_pkg.sv | 22 ++
 rtl/vga_write_arbiter_rr_pick.sv | 45 ++++
 rtl/vga_write_arbiter.sv | 177 +++++++++++++++++
 tb/tb_vga_write_arbiter.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/vga_write_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : vga_write_arbiter_pkg
//  Description : Shared VGA definitions for the pixel write arbiter. Defines
//                the vga_adapter field widths, the screen size, and the
//                arbiter state encodings.
//  Revision    : 1.0 - initial release
// ============================================================================
package vga_write_arbiter_pkg;

    localparam int VGA_X_W      = 9;
    localparam int VGA_Y_W      = 8;
    localparam int VGA_COLOUR_W = 15;
    localparam int SCREEN_W     = 320;
    localparam int SCREEN_H     = 240;

    localparam int ARB_STATE_W = 1;
    localparam logic [ARB_STATE_W-1:0] ARB_IDLE  = 1'b0;
    localparam logic [ARB_STATE_W-1:0] ARB_GRANT = 1'b1;

endpackage
`default_nettype wire

// File: rtl/vga_write_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
//  Module      : vga_write_arbiter_rr_pick
//  Description : Combinational round-robin picker. Starting one position after
//                ptr and wrapping modulo N, it selects the first requester
//                whose req bit is set.
//  Ports       : req     [N]      request vector
//                ptr     [PTR_W]  index of the previous winner
//                sel     [N]      one-hot winner (zero when nothing requests)
//                sel_idx [PTR_W]  binary index of the winner
//                any              at least one request present
//  Revision    : 1.0 - initial release
// ============================================================================
module vga_write_arbiter_rr_pick #(
    parameter int N     = 3,
    parameter int PTR_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     sel,
    output logic [PTR_W-1:0] sel_idx,
    output logic             any
);

    logic [PTR_W-1:0] w_idx;

    // Offsets 1..N visit ptr+1 first and ptr itself last, so the previous
    // winner has the lowest priority.
    always_comb begin
        sel     = '0;
        sel_idx = '0;
        any     = 1'b0;
        w_idx   = '0;
        for (int k = 1; k <= N; k++) begin
            w_idx = PTR_W'((int'(ptr) + k) % N);
            if (!any && req[w_idx]) begin
                sel[w_idx] = 1'b1;
                sel_idx    = w_idx;
                any        = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/vga_write_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : vga_write_arbiter
//  Description : Shares the vga_adapter pixel write port between N drawing
//                engines. Arbitration is round-robin by bursts, and a burst
//                is capped at MAX_BURST pixels. Each pixel uses a valid/ready
//                handshake. The adapter output is registered with one cycle
//                of latency. Off-screen pixels are accepted but not plotted.
//  Ports       : clk, reset (sync, active-low)
//                req/pix_valid/pix_last [N], pix_x [9N], pix_y [8N],
//                pix_colour [15N]          requester side
//                pix_ready/grant [N], busy  handshake / ownership
//                vga_x, vga_y, vga_colour, vga_plot  adapter side
//  Revision    : 1.0 - initial release
// ============================================================================
module vga_write_arbiter
    import vga_write_arbiter_pkg::*;
#(
    parameter int N         = 3,
    parameter int MAX_BURST = 1024,
    parameter int X_MAX     = SCREEN_W,
    parameter int Y_MAX     = SCREEN_H
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [N-1:0]              req,
    input  logic [N-1:0]              pix_valid,
    input  logic [N-1:0]              pix_last,
    input  logic [VGA_X_W*N-1:0]      pix_x,
    input  logic [VGA_Y_W*N-1:0]      pix_y,
    input  logic [VGA_COLOUR_W*N-1:0] pix_colour,
    output logic [N-1:0]              pix_ready,
    output logic [N-1:0]              grant,
    output logic                      busy,
    output logic [VGA_X_W-1:0]        vga_x,
    output logic [VGA_Y_W-1:0]        vga_y,
    output logic [VGA_COLOUR_W-1:0]   vga_colour,
    output logic                      vga_plot
);

    localparam int c_ptr_w = $clog2(N);
    localparam int c_cnt_w = $clog2(MAX_BURST + 1);
    localparam logic [c_cnt_w-1:0] c_max_cnt = c_cnt_w'(MAX_BURST);

    logic [ARB_STATE_W-1:0]  r_state, w_state_nxt;
    logic [N-1:0]            r_grant, w_grant_nxt;
    logic [c_ptr_w-1:0]      r_ptr,   w_ptr_nxt;   // owner while granted, last winner while idle
    logic [c_cnt_w-1:0]      r_count, w_count_nxt, w_count_inc;

    logic [N-1:0]            w_sel;
    logic [c_ptr_w-1:0]      w_sel_idx;
    logic                    w_any;

    logic                    w_own_valid, w_own_last, w_own_req;
    logic [VGA_X_W-1:0]      w_x;
    logic [VGA_Y_W-1:0]      w_y;
    logic [VGA_COLOUR_W-1:0] w_colour;
    logic                    w_xfer, w_exit, w_on_screen;

    logic [VGA_X_W-1:0]      r_vga_x;
    logic [VGA_Y_W-1:0]      r_vga_y;
    logic [VGA_COLOUR_W-1:0] r_vga_colour;
    logic                    r_vga_plot;

    vga_write_arbiter_rr_pick #(
        .N     (N),
        .PTR_W (c_ptr_w)
    ) u_rr_pick (
        .req     (req),
        .ptr     (r_ptr),
        .sel     (w_sel),
        .sel_idx (w_sel_idx),
        .any     (w_any)
    );

    // Select the owner's handshake and pixel fields.
    always_comb begin
        w_own_valid = 1'b0;
        w_own_last  = 1'b0;
        w_own_req   = 1'b0;
        w_x         = '0;
        w_y         = '0;
        w_colour    = '0;
        for (int i = 0; i < N; i++) begin
            if (r_ptr == c_ptr_w'(i)) begin
                w_own_valid = pix_valid[i];
                w_own_last  = pix_last[i];
                w_own_req   = req[i];
                w_x         = pix_x[i*VGA_X_W +: VGA_X_W];
                w_y         = pix_y[i*VGA_Y_W +: VGA_Y_W];
                w_colour    = pix_colour[i*VGA_COLOUR_W +: VGA_COLOUR_W];
            end
        end
    end

    assign w_xfer      = w_own_valid && (r_state == ARB_GRANT);
    assign w_count_inc = r_count + 1'b1;
    // An abort applies only when there is no transfer in the same cycle, so
    // a pixel presented together with a dropped req still completes.
    assign w_exit      = (w_xfer && (w_own_last || (w_count_inc == c_max_cnt)))
                       || (!w_own_req && !w_xfer);
    assign w_on_screen = (32'(w_x) < X_MAX) && (32'(w_y) < Y_MAX);

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= ARB_IDLE;
            r_grant <= '0;
            r_ptr   <= c_ptr_w'(N - 1);
            r_count <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_grant <= w_grant_nxt;
            r_ptr   <= w_ptr_nxt;
            r_count <= w_count_nxt;
        end
    end

    // Every exit passes through IDLE, so there is always at least one idle
    // cycle between grants, including a re-grant to the same requester.
    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        w_ptr_nxt   = r_ptr;
        w_count_nxt = r_count;
        case (r_state)
            ARB_IDLE: begin
                if (w_any) begin
                    w_state_nxt = ARB_GRANT;
                    w_grant_nxt = w_sel;
                    w_ptr_nxt   = w_sel_idx;
                    w_count_nxt = '0;
                end
            end
            ARB_GRANT: begin
                if (w_xfer) begin
                    w_count_nxt = w_count_inc;
                end
                if (w_exit) begin
                    w_state_nxt = ARB_IDLE;
                    w_grant_nxt = '0;
                end
            end
            default: begin
                w_state_nxt = ARB_IDLE;
                w_grant_nxt = '0;
            end
        endcase
    end

    // The adapter register holds x/y/colour between transfers; only plot is
    // cleared.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_vga_x      <= '0;
            r_vga_y      <= '0;
            r_vga_colour <= '0;
            r_vga_plot   <= 1'b0;
        end else begin
            r_vga_plot <= w_xfer && w_on_screen;
            if (w_xfer) begin
                r_vga_x      <= w_x;
                r_vga_y      <= w_y;
                r_vga_colour <= w_colour;
            end
        end
    end

    assign pix_ready  = r_grant;
    assign grant      = r_grant;
    assign busy       = (r_state == ARB_GRANT);
    assign vga_x      = r_vga_x;
    assign vga_y      = r_vga_y;
    assign vga_colour = r_vga_colour;
    assign vga_plot   = r_vga_plot;

endmodule
`default_nettype wire

// File: tb/tb_vga_write_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vga_write_arbiter
//  Description : Self-checking bench for vga_write_arbiter (N=3, MAX_BURST=4).
//                Each requester is fed from a pixel queue. A reference model
//                tracks the owner, the round-robin pointer and the burst
//                count. When a transfer is issued, the expected adapter
//                output is pushed to a scoreboard that a negedge monitor
//                consumes.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_write_arbiter;

    localparam int N         = 3;
    localparam int MAX_BURST = 4;
    localparam int X_MAX     = 320;
    localparam int Y_MAX     = 240;

    logic            clk   = 1'b0;
    logic            reset = 1'b0;
    logic [N-1:0]    req = '0, pix_valid = '0, pix_last = '0;
    logic [9*N-1:0]  pix_x = '0;
    logic [8*N-1:0]  pix_y = '0;
    logic [15*N-1:0] pix_colour = '0;
    logic [N-1:0]    pix_ready, grant;
    logic            busy, vga_plot;
    logic [8:0]      vga_x;
    logic [7:0]      vga_y;
    logic [14:0]     vga_colour;

    vga_write_arbiter #(
        .N(N), .MAX_BURST(MAX_BURST), .X_MAX(X_MAX), .Y_MAX(Y_MAX)
    ) dut (
        .clk(clk), .reset(reset), .req(req), .pix_valid(pix_valid),
        .pix_last(pix_last), .pix_x(pix_x), .pix_y(pix_y),
        .pix_colour(pix_colour), .pix_ready(pix_ready), .grant(grant),
        .busy(busy), .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour),
        .vga_plot(vga_plot)
    );

    always #5 clk = ~clk;

    typedef struct {logic [8:0] x; logic [7:0] y; logic [14:0] c; bit last;} pix_t;
    typedef struct {int cyc; logic [8:0] x; logic [7:0] y; logic [14:0] c; bit plot;} exp_t;

    pix_t         src [N][$];
    exp_t         sb [$];
    int           cyc = 0;
    int           n_pass = 0, n_total = 0;
    int           m_owner = -1, m_rr = N - 1, m_cnt = 0;
    logic [N-1:0] exp_grant = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    endtask

    // Monitor: checks ownership every cycle. It checks the adapter outputs
    // against the scoreboard entry due this cycle. When no entry is due, it
    // checks that plot is low and x/y/colour are held.
    exp_t        mon_e;
    logic [8:0]  hx = '0;
    logic [7:0]  hy = '0;
    logic [14:0] hc = '0;
    always @(negedge clk) begin
        chk("grant", 32'(grant), 32'(exp_grant));
        chk("pix_ready", 32'(pix_ready), 32'(exp_grant));
        chk("busy", 32'(busy), 32'(exp_grant != '0));
        if (sb.size() > 0 && sb[0].cyc == cyc) begin
            mon_e = sb.pop_front();
            chk("vga_plot", 32'(vga_plot), 32'(mon_e.plot));
            chk("vga_x", 32'(vga_x), 32'(mon_e.x));
            chk("vga_y", 32'(vga_y), 32'(mon_e.y));
            chk("vga_colour", 32'(vga_colour), 32'(mon_e.c));
            hx = mon_e.x; hy = mon_e.y; hc = mon_e.c;
        end else begin
            chk("idle_plot", 32'(vga_plot), 32'd0);
            chk("hold_x", 32'(vga_x), 32'(hx));
            chk("hold_y", 32'(vga_y), 32'(hy));
            chk("hold_colour", 32'(vga_colour), 32'(hc));
        end
    end

    task automatic push_px(input int i, input int x, input int y, input int c, input bit last);
        pix_t p;
        p.x = 9'(x); p.y = 8'(y); p.c = 15'(c); p.last = last;
        src[i].push_back(p);
    endtask

    task automatic refill(input int i);
        int len;
        bit with_last;
        len       = $urandom_range(1, 6);
        with_last = ($urandom_range(9) < 7);
        for (int k = 0; k < len; k++)
            push_px(i, $urandom_range(0, 340), $urandom_range(0, 255),
                    $urandom_range(0, 32767), with_last && (k == len - 1));
    endtask

    // One clock cycle: drive the inputs, then advance the reference model.
    // vprob is the percentage chance of pix_valid. dprob is the percentage
    // chance of dropping req while pixels are pending.
    task automatic cycle(input bit rst_v, input int vprob, input int dprob);
        logic [N-1:0] rv, vv;
        pix_t         p;
        int           o, idx;
        bit           found;
        @(posedge clk);
        cyc++;
        #1;
        exp_grant = (m_owner >= 0) ? N'(1 << m_owner) : '0;
        rv = '0; vv = '0;
        for (int i = 0; i < N; i++) begin
            if (src[i].size() > 0) begin
                p = src[i][0];
                rv[i] = ($urandom_range(99) >= dprob);
                vv[i] = ($urandom_range(99) < vprob);
                pix_x[i*9 +: 9]       = p.x;
                pix_y[i*8 +: 8]       = p.y;
                pix_colour[i*15 +: 15] = p.c;
                pix_last[i]           = p.last;
            end else begin
                pix_x[i*9 +: 9]       = 9'($urandom);
                pix_y[i*8 +: 8]       = 8'($urandom);
                pix_colour[i*15 +: 15] = 15'($urandom);
                pix_last[i]           = 1'($urandom);
            end
        end
        reset     = rst_v;
        req       = rv;
        pix_valid = vv;

        if (!rst_v) begin
            sb.push_back('{cyc + 1, 9'd0, 8'd0, 15'd0, 1'b0});
            m_owner = -1; m_rr = N - 1; m_cnt = 0;
        end else if (m_owner < 0) begin
            found = 1'b0;
            for (int k = 1; k <= N; k++) begin
                idx = (m_rr + k) % N;
                if (!found && rv[idx]) begin
                    found = 1'b1; m_owner = idx; m_rr = idx; m_cnt = 0;
                end
            end
        end else begin
            o = m_owner;
            if (vv[o]) begin
                p = src[o].pop_front();
                sb.push_back('{cyc + 1, p.x, p.y, p.c,
                               (int'(p.x) < X_MAX) && (int'(p.y) < Y_MAX)});
                m_cnt++;
                if (p.last || m_cnt == MAX_BURST) m_owner = -1;
            end else if (!rv[o]) begin
                m_owner = -1;
            end
        end
    endtask

    task automatic clear_src();
        for (int i = 0; i < N; i++) src[i].delete();
    endtask

    initial begin
        // Outputs after the power-on reset edge.
        sb.push_back('{1, 9'd0, 8'd0, 15'd0, 1'b0});
        repeat (3) cycle(1'b0, 0, 0);

        // Single burst of four pixels from requester 0.
        for (int k = 0; k < 4; k++) push_px(0, 10 + k, 20, 100 + k, k == 3);
        repeat (10) cycle(1'b1, 100, 0);

        // All three requesters active, two-pixel bursts.
        for (int k = 0; k < 4; k++) push_px(0, 40 + k, 1, 7, k % 2 == 1);
        for (int k = 0; k < 2; k++) push_px(1, 50 + k, 2, 8, k == 1);
        for (int k = 0; k < 2; k++) push_px(2, 60 + k, 3, 9, k == 1);
        repeat (20) cycle(1'b1, 100, 0);

        // Burst cap: requester 0 streams without last while requester 1 waits.
        for (int k = 0; k < 10; k++) push_px(0, k, 100, 1000 + k, 1'b0);
        for (int k = 0; k < 3; k++) push_px(1, 200 + k, 50, 2000 + k, k == 2);
        repeat (30) cycle(1'b1, 100, 0);

        // Clipping boundaries.
        push_px(0, 320, 5, 11, 1'b0);
        push_px(0, 319, 239, 12, 1'b0);
        push_px(0, 0, 240, 13, 1'b1);
        repeat (8) cycle(1'b1, 100, 0);

        // Valid gaps mid-burst, then an abort by dropping req.
        for (int k = 0; k < 6; k++) push_px(0, 70 + k, 70, 3000 + k, k == 5);
        repeat (20) cycle(1'b1, 50, 0);
        for (int k = 0; k < 3; k++) push_px(0, 80 + k, 80, 4000 + k, 1'b0);
        repeat (3) cycle(1'b1, 100, 0);
        repeat (3) cycle(1'b1, 0, 0);
        repeat (4) cycle(1'b1, 0, 100);
        clear_src();

        // Reset in the middle of a burst, then requesters 1 and 2 only.
        for (int k = 0; k < 8; k++) push_px(0, 90 + k, 90, 5000 + k, 1'b0);
        repeat (4) cycle(1'b1, 100, 0);
        cycle(1'b0, 100, 0);
        clear_src();
        for (int k = 0; k < 2; k++) push_px(1, 110 + k, 9, 6000 + k, k == 1);
        for (int k = 0; k < 2; k++) push_px(2, 120 + k, 9, 7000 + k, k == 1);
        repeat (12) cycle(1'b1, 100, 0);

        // Randomised traffic with occasional resets.
        for (int t = 0; t < 1500; t++) begin
            for (int i = 0; i < N; i++)
                if (src[i].size() == 0 && $urandom_range(7) == 0) refill(i);
            cycle($urandom_range(299) != 0, 75, 4);
        end

        clear_src();
        repeat (8) cycle(1'b1, 0, 0);
        @(negedge clk);
        #1;
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
